// File: rtl/vc_scheduler.sv
// Two-VC scheduler feeding two destination FIFOs: VC0 priority with VC1 starvation guard, 1-cycle pop-to-push.
// Define VC_SCHED_STATS_EN to build the per-VC forwarded-word counters (otherwise they read 0).
module vc_scheduler #(
    parameter int DATA_W       = 6,
    parameter int DEST_BIT     = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active_in,
    input  logic              error_in,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic              d1_push,
    output logic [DATA_W-1:0] d_data,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  cnt_vc0,
    output logic [CNT_W-1:0]  cnt_vc1
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              push0_q, push1_q;
    logic [DATA_W-1:0] d_data_q;

    logic              vc0_elig, vc1_elig, starve_hit;
    logic              gnt0, gnt1, grant;
    logic [DATA_W-1:0] gnt_word;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = error_in ? HALT : (active_in ? RUN : IDLE);
            RUN:     state_d = error_in ? HALT : (active_in ? RUN : IDLE);
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // A VC is eligible only if the FIFO its head word targets can take it.
    assign vc0_elig = (state_q == RUN) && !vc0_empty &&
                      !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
    assign vc1_elig = (state_q == RUN) && !vc1_empty &&
                      !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

    assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
    assign gnt1       = vc1_elig && (!vc0_elig || starve_hit);
    assign gnt0       = vc0_elig && !gnt1;
    assign grant      = gnt0 || gnt1;
    assign gnt_word   = gnt1 ? vc1_data : vc0_data;

    always_comb begin
        starve_d = '0;
        if (vc1_elig && gnt0) begin
            starve_d = starve_hit ? starve_q : starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            push0_q  <= 1'b0;
            push1_q  <= 1'b0;
            d_data_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            push0_q  <= grant && !gnt_word[DEST_BIT];
            push1_q  <= grant && gnt_word[DEST_BIT];
            if (grant) begin
                d_data_q <= gnt_word;
            end
        end
    end

    // Pops are combinational, so they must be masked while reset is held.
    assign vc0_pop = gnt0 && !reset;
    assign vc1_pop = gnt1 && !reset;
    assign d0_push = push0_q;
    assign d1_push = push1_q;
    assign d_data  = d_data_q;
    assign state_o = state_q;

`ifdef VC_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0 && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (gnt1 && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign cnt_vc0 = cnt0_q;
    assign cnt_vc1 = cnt1_q;
`else
    assign cnt_vc0 = '0;
    assign cnt_vc1 = '0;
`endif

endmodule

// File: tb/tb_vc_scheduler.sv
// Directed bench for vc_scheduler: pop checks inline, pushes checked by a cycle-tagged scoreboard monitor.
module tb_vc_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       active_in = 1'b0;
    logic       error_in = 1'b0;
    logic       vc0_empty = 1'b0;
    logic       vc1_empty = 1'b0;
    logic [5:0] vc0_data = 6'h01;
    logic [5:0] vc1_data = 6'h02;
    logic       d0_almost_full = 1'b0;
    logic       d1_almost_full = 1'b0;
    logic       vc0_pop, vc1_pop, d0_push, d1_push;
    logic [5:0] d_data;
    logic [1:0] state_o;
    logic [7:0] cnt_vc0, cnt_vc1;

    typedef struct {
        int         cyc;
        logic       dest;
        logic [5:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

`ifdef VC_SCHED_STATS_EN
    localparam int EXP_CNT0 = 255;
    localparam int EXP_CNT1 = 3;
`else
    localparam int EXP_CNT0 = 0;
    localparam int EXP_CNT1 = 0;
`endif

    vc_scheduler #(
        .DATA_W(6), .DEST_BIT(4), .STARVE_LIMIT(4), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .active_in(active_in), .error_in(error_in),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_push(d0_push), .d1_push(d1_push), .d_data(d_data),
        .state_o(state_o), .cnt_vc0(cnt_vc0), .cnt_vc1(cnt_vc1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Each expected push is tagged with the cycle it must appear in.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            mon_e = sb.pop_front();
            checks++;
            if (!(d0_push || d1_push) || mon_e.cyc != cyc_cnt) begin
                errors++;
                $display("FAIL push_missing: cycle %0d got d0_push=%0b d1_push=%0b, required push dest %0d data %h in cycle %0d",
                         cyc_cnt, d0_push, d1_push, mon_e.dest, mon_e.data, mon_e.cyc);
            end else if (d0_push && d1_push) begin
                errors++;
                $display("FAIL push_dual: cycle %0d got both pushes, required only dest %0d", cyc_cnt, mon_e.dest);
            end else if (d1_push !== mon_e.dest || d_data !== mon_e.data) begin
                errors++;
                $display("FAIL push_word: cycle %0d got dest %0d data %h, required dest %0d data %h",
                         cyc_cnt, d1_push, d_data, mon_e.dest, mon_e.data);
            end
        end else if (d0_push || d1_push) begin
            checks++;
            errors++;
            $display("FAIL push_unexpected: cycle %0d got d0_push=%0b d1_push=%0b data %h, required no push",
                     cyc_cnt, d0_push, d1_push, d_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 after inputs are set; checks pops, queues the push, advances one cycle.
    task automatic step(input string nm, input logic p0, input logic p1, input logic [6:0] w);
        exp_t e;
        #1;
        chk({nm, "_vc0_pop"}, {31'd0, vc0_pop}, {31'd0, p0});
        chk({nm, "_vc1_pop"}, {31'd0, vc1_pop}, {31'd0, p1});
        if (p0 || p1) begin
            e.cyc  = cyc_cnt + 1;
            e.dest = w[6];
            e.data = w[5:0];
            sb.push_back(e);
        end
        tick();
    endtask

    logic fair_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_vc0_pop", {31'd0, vc0_pop}, 32'd0);
        chk("rst_vc1_pop", {31'd0, vc1_pop}, 32'd0);
        chk("rst_d0_push", {31'd0, d0_push}, 32'd0);
        chk("rst_d1_push", {31'd0, d1_push}, 32'd0);
        chk("rst_d_data", {26'd0, d_data}, 32'd0);
        chk("rst_cnt0", {24'd0, cnt_vc0}, 32'd0);
        chk("rst_cnt1", {24'd0, cnt_vc1}, 32'd0);
        tick();
        reset = 1'b0;

        // Inactive with both VCs non-empty: stay idle, no pops.
        step("idle", 1'b0, 1'b0, 7'h00);
        step("idle", 1'b0, 1'b0, 7'h00);
        chk("idle_state", {30'd0, state_o}, 32'd0);
        active_in = 1'b1;
        step("enter", 1'b0, 1'b0, 7'h00);
        chk("run_state", {30'd0, state_o}, 32'd1);

        // Starvation guard: four VC0 grants then one VC1.
        for (int i = 0; i < 10; i++) begin
            step("fair", !fair_seq[i], fair_seq[i], fair_seq[i] ? 7'h02 : 7'h01);
        end

        // VC0 head targets D1 which is backpressured: VC1 only.
        vc0_data = 6'h10;
        vc1_data = 6'h05;
        d1_almost_full = 1'b1;
        step("d1_bp", 1'b0, 1'b1, 7'h05);
        step("d1_bp", 1'b0, 1'b1, 7'h05);

        d1_almost_full = 1'b0;
        vc1_empty = 1'b1;
        step("to_d1", 1'b1, 1'b0, {1'b1, 6'h10});
        step("to_d1", 1'b1, 1'b0, {1'b1, 6'h10});

        vc1_empty = 1'b0;
        d0_almost_full = 1'b1;
        d1_almost_full = 1'b1;
        step("all_bp", 1'b0, 1'b0, 7'h00);
        step("all_bp", 1'b0, 1'b0, 7'h00);
        chk("hold_data", {26'd0, d_data}, 32'h10);

        // Grant in the same cycle active_in drops: push still completes.
        d0_almost_full = 1'b0;
        d1_almost_full = 1'b0;
        vc1_empty = 1'b1;
        vc0_data = 6'h01;
        active_in = 1'b0;
        step("drop_active", 1'b1, 1'b0, 7'h01);
        chk("drop_state", {30'd0, state_o}, 32'd0);
        step("idle_after", 1'b0, 1'b0, 7'h00);
        active_in = 1'b1;
        step("reenter", 1'b0, 1'b0, 7'h00);
        chk("reenter_state", {30'd0, state_o}, 32'd1);

        // Error with a grant: push completes, then HALT until reset.
        error_in = 1'b1;
        step("err_grant", 1'b1, 1'b0, 7'h01);
        chk("halt_state", {30'd0, state_o}, 32'd2);
        error_in = 1'b0;
        step("halt", 1'b0, 1'b0, 7'h00);
        step("halt", 1'b0, 1'b0, 7'h00);
        step("halt", 1'b0, 1'b0, 7'h00);
        chk("halt_stay", {30'd0, state_o}, 32'd2);

        reset = 1'b1;
        #1;
        chk("halt_rst_state", {30'd0, state_o}, 32'd0);
        tick();
        reset = 1'b0;
        step("rst_idle", 1'b0, 1'b0, 7'h00);
        chk("rerun_state", {30'd0, state_o}, 32'd1);

        // Reset in the cycle after a pop discards the pending push.
        #1;
        chk("pre_rst_vc0_pop", {31'd0, vc0_pop}, 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_d0_push", {31'd0, d0_push}, 32'd0);
        chk("mid_rst_d1_push", {31'd0, d1_push}, 32'd0);
        chk("mid_rst_d_data", {26'd0, d_data}, 32'd0);
        chk("mid_rst_vc0_pop", {31'd0, vc0_pop}, 32'd0);
        chk("mid_rst_cnt0", {24'd0, cnt_vc0}, 32'd0);
        chk("mid_rst_cnt1", {24'd0, cnt_vc1}, 32'd0);
        tick();
        reset = 1'b0;
        step("post_rst", 1'b0, 1'b0, 7'h00);

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            step("bulk", 1'b1, 1'b0, 7'h01);
        end
        vc0_empty = 1'b1;
        vc1_empty = 1'b0;
        vc1_data = 6'h22;
        step("vc1_run", 1'b0, 1'b1, 7'h22);
        step("vc1_run", 1'b0, 1'b1, 7'h22);
        step("vc1_run", 1'b0, 1'b1, 7'h22);
        vc1_empty = 1'b1;
        step("drain", 1'b0, 1'b0, 7'h00);
        step("drain", 1'b0, 1'b0, 7'h00);
        chk("cnt_vc0_final", {24'd0, cnt_vc0}, EXP_CNT0);
        chk("cnt_vc1_final", {24'd0, cnt_vc1}, EXP_CNT1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_scheduler.md
VC_SCHEDULER -- requirements
Module: vc_scheduler

Interface
REQ-001 Parameter DATA_W, default 6, word width of VC and destination FIFO data.
REQ-002 Parameter DEST_BIT, default 4, index of the data bit that selects the destination (0 = D0, 1 = D1).
REQ-003 Parameter STARVE_LIMIT, default 4, number of consecutive VC1 losses that forces one VC1 grant.
REQ-004 Parameter CNT_W, default 8, width of the statistics counters.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 active_in  input  1  scheduling enable, driven from the top-level FSM active output.
REQ-008 error_in  input  1  fatal error indication; any FIFO error.
REQ-009 vc0_empty, vc1_empty  input  1 each  VC FIFO empty flags.
REQ-010 vc0_data, vc1_data  input  DATA_W each  first-word-fall-through head word of each VC FIFO.
REQ-011 d0_almost_full, d1_almost_full  input  1 each  destination FIFO backpressure.
REQ-012 vc0_pop, vc1_pop  output  1 each  combinational pop strobes to the VC FIFOs.
REQ-013 d0_push, d1_push  output  1 each  registered push strobes to the destination FIFOs.
REQ-014 d_data  output  DATA_W  registered word shared by both destination FIFOs.
REQ-015 state_o  output  2  current state (00 IDLE, 01 RUN, 10 HALT).
REQ-016 cnt_vc0, cnt_vc1  output  CNT_W each  words forwarded per VC (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, RUN and HALT; illegal encodings SHALL go to IDLE.
REQ-018 IDLE -> RUN when active_in=1 and error_in=0; RUN -> IDLE when active_in=0; IDLE or RUN -> HALT when error_in=1; HALT SHALL exit only through reset.
REQ-019 error_in SHALL take priority over active_in in every state.
REQ-020 VCk is eligible only in RUN, with vck_empty=0 and the almost_full of the destination selected by vck_data[DEST_BIT] equal to 0.
REQ-021 At most one pop per cycle: VC0 wins when both are eligible, except when the starvation counter equals STARVE_LIMIT, in which case VC1 wins.
REQ-022 Starvation counter: increment (saturating at STARVE_LIMIT) when VC1 is eligible and VC0 is granted; clear when VC1 is granted or VC1 is not eligible.
REQ-023 The pop SHALL be asserted in the grant cycle. In the next cycle, d_data SHALL hold the granted head word, and exactly one of d0_push/d1_push SHALL be asserted per its DEST_BIT. Pop-to-push latency is 1 cycle.
REQ-024 Without a grant, both pushes SHALL be 0 in the next cycle and d_data SHALL hold its last value.
REQ-025 A push registered in the cycle of a RUN->IDLE or RUN->HALT transition SHALL still complete; no new pop SHALL follow.
REQ-026 Back-to-back grants SHALL be allowed every cycle, giving full throughput.
REQ-027 No pop SHALL be asserted to an empty VC; no push SHALL be derived from a cycle without a pop.

Reset
REQ-028 While reset=1: state=IDLE, starvation counter=0, d0_push=d1_push=0, d_data=0, cnt_vc0=cnt_vc1=0, and vc0_pop=vc1_pop=0 (forced combinationally).
REQ-029 Reset asserted mid-transfer SHALL discard the pending push immediately, with no push on the first cycle after release.

Configuration
REQ-030 Macro VC_SCHED_STATS_EN defined: cnt_vc0/cnt_vc1 SHALL increment on each VC0/VC1 pop, saturate at 2^CNT_W-1, and clear only on reset.
REQ-031 Macro VC_SCHED_STATS_EN undefined: counter logic SHALL be absent and cnt_vc0/cnt_vc1 SHALL be constant 0.

Verification
REQ-032 Both VCs non-empty, all heads DEST_BIT=0, no backpressure, STARVE_LIMIT=4 -> pop sequence VC0,VC0,VC0,VC0,VC1,VC0...; d0_push each cycle, one cycle after each pop.
REQ-033 vc0_data=6'h10 (dest D1), d1_almost_full=1, vc1_data=6'h05 -> only vc1_pop; next cycle d0_push=1 and d_data=6'h05.
REQ-034 RUN with a grant, error_in=1 in the same cycle -> push completes next cycle, state_o=10, no further pops until reset.
REQ-035 active_in=0 with both VCs non-empty -> no pop, state_o=00; active_in=1 -> first pop on the next cycle after entering RUN.
REQ-036 reset pulse in the cycle after a pop -> d0_push/d1_push=0 immediately, d_data=0; with VC_SCHED_STATS_EN, cnt_vc0=cnt_vc1=0.
REQ-037 VC_SCHED_STATS_EN, CNT_W=8, 300 VC0 pops -> cnt_vc0=255; undefined -> cnt_vc0=0.
